// File: rtl/calc_stack_pkg.sv
// Shared definitions for the controller's operator and operand stacks.
// Latency: n/a (types and constants only).
// Backpressure: n/a; over/underflow is reported through the sticky err flag.
package calc_stack_pkg;

  // Default entry widths for the two stack instances (operator / operand).
  localparam int CO_N = 8;
  localparam int CD_N = 16;

  // Stack command as seen on {push, pop}.
  typedef enum logic [1:0] {
    CMD_HOLD    = 2'b00,
    CMD_POP     = 2'b01,
    CMD_PUSH    = 2'b10,
    CMD_REPLACE = 2'b11
  } stack_cmd_e;

  function automatic stack_cmd_e decode_cmd(input logic push, input logic pop);
    return stack_cmd_e'({push, pop});
  endfunction

endpackage

// File: rtl/calc_stack.sv
// Synchronous LIFO backing the controller's operator or operand stack.
// Latency: 0 -- top-of-stack is combinational; push/pop show right after the edge.
// Backpressure: none; push when full / pop when empty sets the sticky err flag.
//
// Ports:
//   Clock  - rising-edge clock
//   Reset  - synchronous active-high reset (count=0, err=0)
//   clear  - synchronous flush; beats push/pop in the same cycle
//   push   - write din as new top (with pop: replace top)
//   pop    - remove current top
//   din    - entry to push
//   data   - current top entry, zero when empty
//   empty  - no entries held
//   full   - DEPTH entries held
//   count  - number of entries, 0..DEPTH
//   err    - sticky overflow/underflow flag
module calc_stack
  import calc_stack_pkg::*;
#(
  parameter int WIDTH = CO_N,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             err
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      count_m1;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             wr_en;
  stack_cmd_e       cmd;

  assign cmd      = decode_cmd(push, pop);
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign count_m1 = count - ONE_C;
  // Only meaningful when not empty; the data mux below masks the empty case.
  assign top_idx  = count_m1[AW-1:0];
  assign data     = empty ? '0 : mem[top_idx];

  // Replace on a non-empty stack overwrites the top; every other write lands
  // at count, which is slot 0 for a replace on an empty stack.
  always_comb begin
    wr_idx = count[AW-1:0];
    wr_en  = 1'b0;
    if (!Reset && !clear) begin
      case (cmd)
        CMD_PUSH: wr_en = !full;
        CMD_REPLACE: begin
          wr_en = 1'b1;
          if (!empty) wr_idx = top_idx;
        end
        default: wr_en = 1'b0;
      endcase
    end
  end

  // Storage is not reset; reads are masked to zero until entries are written.
  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_idx] <= din;
  end

  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      case (cmd)
        CMD_PUSH: begin
          if (full) err   <= 1'b1;
          else      count <= count + ONE_C;
        end
        CMD_POP: begin
          if (empty) err   <= 1'b1;
          else       count <= count_m1;
        end
        CMD_REPLACE: begin
          // Underflowing replace still pushes din as the sole entry.
          if (empty) begin
            count <= ONE_C;
            err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
